// File: rtl/mc_pkg.sv
// mc_pkg: shared state codes, opcodes, alu_op codes and control word for the multicycle controller
package mc_pkg;
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;
  function automatic logic legal_op(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  endfunction
endpackage

// File: rtl/multicycle_ctrl_decode.sv
// multicycle_ctrl_decode: state -> control word (in: state, rdy, opcode; out: ctrl), purely combinational
module multicycle_ctrl_decode
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic       rdy,
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ir_write  = rdy;
        ctrl.pc_write  = rdy;
      end
      DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ALU_ADD;
        ctrl.illegal   = !legal_op(opcode);
      end
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALU_ADD;
      end
      MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
      end
      ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALU_ADD;
      end
      ADDIWB: ctrl.reg_write = 1'b1;
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
      end
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS control FSM (in: clk, reset_n, opcode, mem_ready; out: datapath enables/selects, state, illegal)
module multicycle_control
  import mc_pkg::*;
#(
  parameter bit IGNORE_READY = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal
);
  state_t st, nx;
  ctrl_t dc, c;
  logic rdy;
  assign rdy = IGNORE_READY || mem_ready;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) st <= FETCH;
    else st <= nx;
  always_comb begin
    nx = FETCH;
    case (st)
      FETCH:  nx = rdy ? DECODE : FETCH;
      DECODE: nx = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                   opcode == OP_R    ? EXEC   :
                   opcode == OP_BEQ  ? BRANCH :
                   opcode == OP_ADDI ? ADDIEX :
                   opcode == OP_J    ? JUMP   : FETCH;
      MEMADR: nx = opcode == OP_SW ? MEMWR : MEMRD;
      MEMRD:  nx = rdy ? MEMWB : MEMRD;
      MEMWR:  nx = rdy ? FETCH : MEMWR;
      EXEC:   nx = ALUWB;
      ADDIEX: nx = ADDIWB;
      default: nx = FETCH;
    endcase
  end
  multicycle_ctrl_decode u_decode (
    .state (st),
    .rdy   (rdy),
    .opcode(opcode),
    .ctrl  (dc)
  );
  // Gate with reset_n so FETCH's mem_read is not visible while reset is held.
  assign c             = reset_n ? dc : '0;
  assign pc_write      = c.pc_write;
  assign pc_write_cond = c.pc_write_cond;
  assign iord          = c.iord;
  assign mem_read      = c.mem_read;
  assign mem_write     = c.mem_write;
  assign ir_write      = c.ir_write;
  assign mem_to_reg    = c.mem_to_reg;
  assign reg_write     = c.reg_write;
  assign reg_dst       = c.reg_dst;
  assign alu_src_a     = c.alu_src_a;
  assign alu_src_b     = c.alu_src_b;
  assign alu_op        = c.alu_op;
  assign pc_source     = c.pc_source;
  assign illegal       = c.illegal;
  assign state         = st;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: path-based model check plus directed literal expectations
module tb_multicycle_control;
  import mc_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = 6'b0;
  logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_write, reg_dst, alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic [16:0] outs;
  int vectors = 0, miscompares = 0;
  int mstate = 0;
  logic [20:0] trace[$];

  multicycle_control #(.IGNORE_READY(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign outs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
                 pc_source, illegal};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Output table straight from the per-state rules.
  function automatic logic [16:0] exp_out(input int s, input logic rdy, input logic [5:0] op);
    logic pw, pwc, io, mr, mw, irw, m2r, rw, rd, sa, il;
    logic [1:0] sb, ao, ps;
    {pw, pwc, io, mr, mw, irw, m2r, rw, rd, sa, il} = '0;
    {sb, ao, ps} = '0;
    case (s)
      0: begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
      1: begin sb = 2'b11; il = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000}); end
      2: begin sa = 1; sb = 2'b10; end
      3: begin mr = 1; io = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mw = 1; io = 1; end
      6: begin sa = 1; ao = 2'b10; end
      7: begin rw = 1; rd = 1; end
      8: begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
      9: begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin pw = 1; ps = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, io, mr, mw, irw, m2r, rw, rd, sa, sb, ao, ps, il};
  endfunction

  // Next state from the instruction's state path; memory states wait for ready.
  function automatic int mnext(input int s, input logic rdy, input logic [5:0] op);
    int p[$];
    if ((s == 0 || s == 3 || s == 5) && !rdy) return s;
    if (s >= 12) return 0;
    case (op)
      6'b100011: p = {0, 1, 2, 3, 4};
      6'b101011: p = {0, 1, 2, 5};
      6'b000000: p = {0, 1, 6, 7};
      6'b001000: p = {0, 1, 9, 10};
      6'b000100: p = {0, 1, 8};
      6'b000010: p = {0, 1, 11};
      default:   p = {0, 1};
    endcase
    foreach (p[i]) if (p[i] == s) return (i + 1 < p.size()) ? p[i + 1] : 0;
    return 0;
  endfunction

  always @(posedge clk or negedge reset_n)
    if (!reset_n) mstate <= 0;
    else mstate <= mnext(mstate, mem_ready, opcode);

  always @(negedge clk) begin
    logic [16:0] e;
    e = reset_n ? exp_out(mstate, mem_ready, opcode) : 17'b0;
    chk("cycle_state", {28'b0, state}, mstate);
    chk("cycle_outs", {15'b0, outs}, {15'b0, e});
    chk("rd_wr_excl", {31'b0, mem_read & mem_write}, 0);
    trace.push_back({state, outs});
  end

  task automatic instr(input string name, input logic [5:0] op, input int fs, input int ms,
                       input int lat_exp, input int st_exp[$]);
    int prev, cyc;
    bit done;
    cyc = 0;
    done = 0;
    opcode = op;
    trace.delete();
    while (!done && cyc < 60) begin
      if (mstate == 0 && fs > 0) begin mem_ready = 0; fs--; end
      else if ((mstate == 3 || mstate == 5) && ms > 0) begin mem_ready = 0; ms--; end
      else mem_ready = 1;
      prev = mstate;
      @(posedge clk);
      #1;
      cyc++;
      done = prev != 0 && mstate == 0;
    end
    chk({name, "_latency"}, cyc, lat_exp);
    chk({name, "_len"}, trace.size(), st_exp.size());
    foreach (st_exp[i]) if (i < trace.size()) chk({name, "_path"}, {28'b0, trace[i][20:17]}, st_exp[i]);
    chk({name, "_end"}, {28'b0, state}, 0);
  endtask

  initial begin
    #12;
    chk("reset_state", {28'b0, state}, 0);
    chk("reset_outs", {15'b0, outs}, 0);
    @(posedge clk);
    #1;
    reset_n = 1;
    instr("lw", 6'b100011, 0, 0, 5, {0, 1, 2, 3, 4});
    for (int i = 0; i < 5; i++) if (i < trace.size()) begin
      chk("lw_reg_write", {31'b0, trace[i][9]}, {31'b0, i == 4});
      chk("lw_mem_to_reg", {31'b0, trace[i][10]}, {31'b0, i == 4});
    end
    instr("sw", 6'b101011, 0, 3, 7, {0, 1, 2, 5, 5, 5, 5});
    for (int i = 3; i < 7; i++) if (i < trace.size()) chk("sw_mem_write", {31'b0, trace[i][12]}, 1);
    instr("r_fetch_stall", 6'b000000, 2, 0, 6, {0, 0, 0, 1, 6, 7});
    for (int i = 0; i < 3; i++) if (i < trace.size()) begin
      chk("fetch_ir_write", {31'b0, trace[i][11]}, {31'b0, i == 2});
      chk("fetch_pc_write", {31'b0, trace[i][16]}, {31'b0, i == 2});
    end
    instr("illegal", 6'b111111, 0, 0, 2, {0, 1});
    if (trace.size() > 1) begin
      chk("illegal_pulse", {31'b0, trace[1][0]}, 1);
      chk("illegal_no_wr", {27'b0, trace[1][16], trace[1][15], trace[1][12], trace[1][11], trace[1][9]}, 0);
    end
    instr("beq", 6'b000100, 0, 0, 3, {0, 1, 8});
    if (trace.size() > 2) begin
      chk("beq_alu_op", {30'b0, trace[2][4:3]}, 1);
      chk("beq_pwc", {31'b0, trace[2][15]}, 1);
    end
    instr("j", 6'b000010, 0, 0, 3, {0, 1, 11});
    if (trace.size() > 2) chk("j_pc_source", {30'b0, trace[2][2:1]}, 2);
    instr("addi", 6'b001000, 0, 0, 4, {0, 1, 9, 10});
    instr("lw_stall", 6'b100011, 0, 2, 7, {0, 1, 2, 3, 3, 3, 4});
    opcode = 6'b100011;
    mem_ready = 1;
    for (int k = 0; k < 10 && mstate != 3; k++) begin
      @(posedge clk);
      #1;
    end
    chk("reach_memrd", {28'b0, state}, 3);
    mem_ready = 0;
    #1 reset_n = 0;
    #1;
    chk("async_rst_state", {28'b0, state}, 0);
    chk("async_rst_mem_read", {31'b0, mem_read}, 0);
    chk("async_rst_outs", {15'b0, outs}, 0);
    #1 reset_n = 1;
    #1;
    chk("post_rst_fetch", {28'b0, state}, 0);
    chk("post_rst_mem_read", {31'b0, mem_read}, 1);
    mem_ready = 1;
    @(posedge clk);
    #1;
    chk("post_rst_decode", {28'b0, state}, 1);
    for (int k = 0; k < 20 && mstate != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("post_rst_done", {28'b0, state}, 0);
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter IGNORE_READY, default 0; 1 means memory states complete in one cycle and mem_ready is ignored.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port opcode, input, 6, instruction bits [31:26] from the instruction register.
REQ-005 SHALL have port mem_ready, input, 1, memory access completes this cycle.
REQ-006 SHALL have ports pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a, output, 1 each, datapath enables and selects.
REQ-007 SHALL have ports alu_src_b, alu_op, pc_source, output, 2 each; alu_op feeds the ALU control decoder.
REQ-008 SHALL have port state, output, 4, current state encoding.
REQ-009 SHALL have port illegal, output, 1, one-cycle pulse on an unsupported opcode.

Function
REQ-010 SHALL be a Moore FSM: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 unused.
REQ-011 SHALL use opcodes R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
REQ-012 SHALL use alu_op encodings 00 add, 01 subtract, 10 funct-decoded, 11 reserved (never driven).
REQ-013 SHALL, in FETCH, drive mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; it SHALL assert ir_write=1 and pc_write=1 only in the cycle where mem_ready=1, and SHALL stay in FETCH otherwise.
REQ-014 SHALL, in DECODE, drive alu_src_a=0, alu_src_b=11, alu_op=00. Next state: lw/sw to MEMADR, R to EXEC, beq to BRANCH, addi to ADDIEX, j to JUMP, any other opcode to FETCH with illegal=1 for that DECODE cycle.
REQ-015 SHALL, in MEMADR, drive alu_src_a=1, alu_src_b=10, alu_op=00. Next state: MEMRD for lw, MEMWR for sw.
REQ-016 SHALL, in MEMRD, hold mem_read=1 and iord=1 until mem_ready=1, then go to MEMWB.
REQ-017 SHALL, in MEMWB, drive reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-018 SHALL, in MEMWR, hold mem_write=1 and iord=1 until mem_ready=1, then go to FETCH.
REQ-019 SHALL, in EXEC, drive alu_src_a=1, alu_src_b=00, alu_op=10, then go to ALUWB; in ALUWB it SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-020 SHALL, in BRANCH, drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, then go to FETCH.
REQ-021 SHALL, in ADDIEX, drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to ADDIWB; in ADDIWB it SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0, then go to FETCH.
REQ-022 SHALL, in JUMP, drive pc_write=1, pc_source=10, then go to FETCH.
REQ-023 SHALL drive 0 on every output not listed for the current state; mem_read and mem_write SHALL never both be 1.
REQ-024 SHALL, from an unused state code, go to FETCH on the next edge with all outputs 0.
REQ-025 SHALL, with IGNORE_READY=1, treat mem_ready as constant 1.
REQ-026 SHALL give instruction latencies (mem_ready always 1) of lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles.

Reset
REQ-027 SHALL, while reset_n=0, force state=FETCH and all other outputs to 0 immediately, independent of clk.
REQ-028 SHALL, on the first rising edge after reset_n rises, begin FETCH with mem_read=1; a reset mid-instruction SHALL abandon the instruction with no write enable asserted.

Structure
REQ-029 SHALL take opcode constants, state encodings and alu_op encodings from a shared package, mc_pkg.
REQ-030 SHALL put the state-to-output decode in a purely combinational sub-module, multicycle_ctrl_decode; the next-state logic and the state register SHALL stay in the top module.

Verification
REQ-031 SHALL check: lw with mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-032 SHALL check: sw with mem_ready low for 3 cycles in MEMWR -> state 5 held for 4 cycles with mem_write=1, then state 0.
REQ-033 SHALL check: FETCH with mem_ready=0 for 2 cycles -> ir_write=0 and pc_write=0 for 2 cycles, then both 1 for one cycle.
REQ-034 SHALL check: opcode 111111 in DECODE -> illegal=1 for one cycle, next state 0, no write enable asserted.
REQ-035 SHALL check: beq -> states 0,1,8,0 with alu_op=01 and pc_write_cond=1 in state 8; j -> states 0,1,11,0 with pc_source=10.
REQ-036 SHALL check: reset_n pulled low in state 3 between clock edges -> state=0 and mem_read=0 at once; after release the first cycle is FETCH.
